stpmtr_arb: RTL and testbench

- Round-robin arbiter and sequencer sharing one stpmtr position-command interface between N_REQ requesters (e.g. UI panel, host, homing logic).
- Validates the requested absolute position, issues it to the motor controller, and waits for the motor acknowledge.
- Returns a per-requester one-cycle ack or error pulse.
- Sits between the requesters and stpmtr on the 1 kHz motor clock domain.

---
 rtl/stpmtr_pkg.sv | 15 +
 rtl/stpmtr_rr_pick.sv | 29 ++
 rtl/stpmtr_arb.sv | 135 +++++++++++++
 tb/tb_stpmtr_arb.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/stpmtr_pkg.sv
// Shared constants and types for the stepper-motor command path.
// Position width/range, FSM state encoding, default ack timeout.
package stpmtr_pkg;

    localparam int unsigned POS_W       = 8;
    localparam int unsigned POS_MAX     = 240;
    localparam int unsigned TIMEOUT_DEF = 1023;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/stpmtr_rr_pick.sv
// Round-robin winner search: first set request at or above ptr,
// wrapping modulo N_REQ (works for non-power-of-two counts).
module stpmtr_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             found,
    output logic [IW-1:0]    idx
);

    int unsigned k;

    // Scan N_REQ slots starting at ptr; keep the first hit only
    always_comb begin
        found = 1'b0;
        idx   = '0;
        k     = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            k = (32'(ptr) + i) % N_REQ;
            if (!found && req[k]) begin
                found = 1'b1;
                idx   = IW'(k);
            end
        end
    end

endmodule

// File: rtl/stpmtr_arb.sv
// Round-robin arbiter sharing one stpmtr position port between
// N_REQ requesters; range-checks, issues, waits for ack or timeout.
module stpmtr_arb #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned POS_MAX = stpmtr_pkg::POS_MAX,
    parameter int unsigned TIMEOUT = stpmtr_pkg::TIMEOUT_DEF,
    parameter int unsigned IW      = $clog2(N_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_pos_i,
    output logic [N_REQ-1:0]   req_ack_o,
    output logic [N_REQ-1:0]   req_err_o,
    output logic [7:0]         mot_pos_o,
    output logic               mot_valid_o,
    input  logic               mot_ack_i,
    output logic               busy_o,
    output logic [IW-1:0]      gnt_idx_o
);

    import stpmtr_pkg::*;

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [POS_W-1:0] PMAX = POS_W'(POS_MAX);

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    gnt_q, gnt_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             mval_q, mval_d;
    logic             busy_q, busy_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [N_REQ-1:0] err_q, err_d;

    logic             found;
    logic [IW-1:0]    win;
    logic [POS_W-1:0] win_pos;

    stpmtr_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req   (req_valid_i),
        .ptr   (ptr_q),
        .found (found),
        .idx   (win)
    );

    assign win_pos = req_pos_i[POS_W*win +: POS_W];

    // Next-state and next-output decode
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        timer_d = timer_q;
        pos_d   = pos_q;
        mval_d  = mval_q;
        ack_d   = '0;
        err_d   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d = win;
                    ptr_d = (win == IW'(N_REQ - 1)) ? '0 : win + IW'(1);
                    if (win_pos > PMAX) begin
                        err_d[win] = 1'b1;
                        state_d    = S_RESP;
                    end else begin
                        pos_d   = win_pos;
                        mval_d  = 1'b1;
                        timer_d = '0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (mot_ack_i) begin
                    mval_d       = 1'b0;
                    ack_d[gnt_q] = 1'b1;
                    state_d      = S_RESP;
                end else if (timer_q == TLAST) begin
                    mval_d       = 1'b0;
                    err_d[gnt_q] = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            timer_q <= '0;
            pos_q   <= '0;
            mval_q  <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            timer_q <= timer_d;
            pos_q   <= pos_d;
            mval_q  <= mval_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign req_ack_o   = ack_q;
    assign req_err_o   = err_q;
    assign mot_pos_o   = pos_q;
    assign mot_valid_o = mval_q;
    assign busy_o      = busy_q;
    assign gnt_idx_o   = gnt_q;

endmodule

// File: tb/tb_stpmtr_arb.sv
// Directed bench for stpmtr_arb: single command, fairness, range,
// timeout, ack-on-timeout boundary, async reset mid-issue.
module tb_stpmtr_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 1023;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_pos;
    logic [3:0]  req_ack;
    logic [3:0]  req_err;
    logic [7:0]  mot_pos;
    logic        mot_valid;
    logic        mot_ack;
    logic        busy;
    logic [1:0]  gnt_idx;

    int total;
    int bad;
    int cnt;

    stpmtr_arb #(
        .N_REQ   (N),
        .POS_MAX (240),
        .TIMEOUT (TO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_pos_i   (req_pos),
        .req_ack_o   (req_ack),
        .req_err_o   (req_err),
        .mot_pos_o   (mot_pos),
        .mot_valid_o (mot_valid),
        .mot_ack_i   (mot_ack),
        .busy_o      (busy),
        .gnt_idx_o   (gnt_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_pos   = '0;
        mot_ack   = 1'b0;
        step(2);
        chk("rst_valid", 32'(mot_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pos", 32'(mot_pos), 32'd0);
        chk("rst_gnt", 32'(gnt_idx), 32'd0);
        chk("rst_pulse", 32'({req_ack, req_err}), 32'd0);
        rst_n = 1'b1;
        step(1);
        chk("idle_busy", 32'(busy), 32'd0);

        // motor ack outside ISSUE has no effect
        mot_ack = 1'b1;
        step(1);
        chk("stray_ack", 32'(req_ack), 32'd0);
        chk("stray_busy", 32'(busy), 32'd0);
        mot_ack = 1'b0;

        // single command, motor acks 5 cycles after request
        req_pos   = {8'd0, 8'd0, 8'd0, 8'd100};
        req_valid = 4'b0001;
        step(1);
        chk("s_valid", 32'(mot_valid), 32'd1);
        chk("s_pos", 32'(mot_pos), 32'd100);
        chk("s_gnt", 32'(gnt_idx), 32'd0);
        chk("s_busy", 32'(busy), 32'd1);
        req_valid = 4'b0000;
        step(4);
        chk("s_hold", 32'(mot_valid), 32'd1);
        mot_ack = 1'b1;
        step(1);
        mot_ack = 1'b0;
        chk("s_ack", 32'(req_ack), 32'h1);
        chk("s_vdrop", 32'(mot_valid), 32'd0);
        step(1);
        chk("s_ack_end", 32'(req_ack), 32'h0);
        chk("s_idle", 32'(busy), 32'd0);

        // fairness: everybody valid, grants rotate 0,1,2,3,0
        do_reset();
        req_pos   = {8'd40, 8'd30, 8'd20, 8'd10};
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            step(1);
            chk("f_gnt", 32'(gnt_idx), 32'(n % 4));
            chk("f_pos", 32'(mot_pos), 32'(10 * (n % 4 + 1)));
            mot_ack = 1'b1;
            step(1);
            mot_ack = 1'b0;
            chk("f_ack", 32'(req_ack), 32'(1 << (n % 4)));
            chk("f_err", 32'(req_err), 32'd0);
            step(1);
            chk("f_clr", 32'(req_ack), 32'd0);
        end
        req_valid = 4'b0000;
        step(1);

        // range: 241 rejected without motor, 240 accepted
        req_pos   = {8'd0, 8'd241, 8'd0, 8'd0};
        req_valid = 4'b0100;
        step(1);
        chk("r_err", 32'(req_err), 32'h4);
        chk("r_nomot", 32'(mot_valid), 32'd0);
        chk("r_gnt", 32'(gnt_idx), 32'd2);
        req_valid = 4'b0000;
        step(1);
        chk("r_err_end", 32'(req_err), 32'd0);
        chk("r_nomot2", 32'(mot_valid), 32'd0);
        req_pos   = {8'd0, 8'd240, 8'd0, 8'd0};
        req_valid = 4'b0100;
        step(1);
        chk("r240_valid", 32'(mot_valid), 32'd1);
        chk("r240_pos", 32'(mot_pos), 32'd240);
        mot_ack = 1'b1;
        step(1);
        mot_ack   = 1'b0;
        req_valid = 4'b0000;
        chk("r240_ack", 32'(req_ack), 32'h4);
        step(1);

        // timeout: ptr is 3, so requester 0 wins, then 1
        req_pos   = {8'd0, 8'd0, 8'd60, 8'd50};
        req_valid = 4'b0011;
        cnt       = 0;
        do begin
            step(1);
            cnt++;
            if (cnt == 500) chk("t_wait", 32'(mot_valid), 32'd1);
        end while (req_err == 4'b0000 && cnt < 2000);
        chk("t_cycles", 32'(cnt), 32'(TO + 1));
        chk("t_err", 32'(req_err), 32'h1);
        chk("t_ack", 32'(req_ack), 32'd0);
        chk("t_vdrop", 32'(mot_valid), 32'd0);
        req_valid = 4'b0010;
        step(1);
        chk("t_err_end", 32'(req_err), 32'd0);
        step(1);
        chk("t_next_gnt", 32'(gnt_idx), 32'd1);
        chk("t_next_pos", 32'(mot_pos), 32'd60);
        mot_ack = 1'b1;
        step(1);
        mot_ack   = 1'b0;
        req_valid = 4'b0000;
        chk("t_next_ack", 32'(req_ack), 32'h2);
        step(1);

        // ack arrives exactly on the timeout cycle: ack wins
        req_pos   = {8'd0, 8'd77, 8'd0, 8'd0};
        req_valid = 4'b0100;
        step(1);
        chk("b_gnt", 32'(gnt_idx), 32'd2);
        step(TO - 1);
        chk("b_still", 32'(mot_valid), 32'd1);
        chk("b_noerr", 32'(req_err), 32'd0);
        mot_ack = 1'b1;
        step(1);
        mot_ack   = 1'b0;
        req_valid = 4'b0000;
        chk("b_ack", 32'(req_ack), 32'h4);
        chk("b_err", 32'(req_err), 32'd0);
        step(1);

        // reset while waiting in ISSUE
        req_pos   = {8'd5, 8'd0, 8'd0, 8'd9};
        req_valid = 4'b1000;
        step(1);
        chk("x_gnt", 32'(gnt_idx), 32'd3);
        chk("x_valid", 32'(mot_valid), 32'd1);
        step(3);
        rst_n = 1'b0;
        #1;
        chk("x_async", 32'(mot_valid), 32'd0);
        chk("x_busy", 32'(busy), 32'd0);
        chk("x_gnt0", 32'(gnt_idx), 32'd0);
        chk("x_pos0", 32'(mot_pos), 32'd0);
        step(2);
        chk("x_pulse", 32'({req_ack, req_err}), 32'd0);
        req_valid = 4'b1001;
        rst_n     = 1'b1;
        step(1);
        chk("x_first", 32'(gnt_idx), 32'd0);
        chk("x_fpos", 32'(mot_pos), 32'd9);
        mot_ack = 1'b1;
        step(1);
        mot_ack   = 1'b0;
        req_valid = 4'b1000;
        chk("x_ack", 32'(req_ack), 32'h1);
        step(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
